// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light controller and its timing stage.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_NS_GREEN  = 2'd0,
    PH_NS_YELLOW = 2'd1,
    PH_EW_GREEN  = 2'd2,
    PH_EW_YELLOW = 2'd3
  } phase_e;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_COUNT = 2'd1,
    ST_CLEAR = 2'd2,
    ST_STEP  = 2'd3
  } timer_state_e;

  function automatic logic phase_is_green(input logic [1:0] ph);
    return ~ph[0];
  endfunction

  // Bit 1 of the phase code selects the street: 0 = north/south, 1 = east/west.
  function automatic logic phase_is_ew(input logic [1:0] ph);
    return ph[1];
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clk-to-tick divider with freeze and synchronous restart.
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // tick is registered from the next count, so it is high exactly while the
  // count sits at LAST and stays high if the count is frozen there.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/traffic_phase_timer.sv
// Actuated green / yellow / all-red timing stage; pulses advance_o to step
// the downstream 4-phase controller.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int TICK_DIV  = 1000,
  parameter int GREEN_MIN = 10,
  parameter int GREEN_MAX = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       phase_i,
  input  logic             car_ns,
  input  logic             car_ew,
  input  logic             ped_req,
  output logic             advance_o,
  output logic             all_red_o,
  output logic             tick_o,
  output logic [CNT_W-1:0] remaining_o
);

  localparam logic [CNT_W-1:0] G_MIN = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] G_MAX = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] Y_T   = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] A_T   = CNT_W'(ALLRED_T);

  timer_state_e     state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             dem_ns_q, dem_ns_d;
  logic             dem_ew_q, dem_ew_d;
  logic             advance_q, advance_d;
  logic             all_red_q, all_red_d;

  logic             tick;
  logic             tick_en;
  logic             presc_clear;
  logic             resync;
  logic [CNT_W-1:0] elapsed_inc;
  logic             cross_dem;
  logic             own_car;
  logic             green_expire;
  logic             yellow_expire;
  logic             clear_done;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (presc_clear),
    .tick   (tick)
  );

  assign tick_en     = tick & enable;
  assign resync      = (phase_i != phase_q);
  assign elapsed_inc = (elapsed_q >= G_MAX) ? G_MAX : elapsed_q + 1'b1;

  always_comb begin
    if (phase_is_ew(phase_q)) begin
      cross_dem = dem_ns_q;
      own_car   = car_ew;
    end else begin
      cross_dem = dem_ew_q;
      own_car   = car_ns;
    end
  end

  // Green only yields to a waiting cross street; own traffic may stretch it to GREEN_MAX.
  assign green_expire  = (elapsed_inc >= G_MIN) && cross_dem &&
                         (!own_car || (elapsed_inc >= G_MAX));
  assign yellow_expire = (elapsed_inc >= Y_T);
  assign clear_done    = (elapsed_inc >= A_T);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (enable) begin
      case (state_q)
        ST_LOAD: state_d = ST_COUNT;
        ST_COUNT: begin
          if (resync) begin
            state_d = ST_LOAD;
          end else if (tick_en) begin
            if (phase_is_green(phase_q)) begin
              if (green_expire) state_d = ST_STEP;
            end else if (yellow_expire) begin
              state_d = (ALLRED_T == 0) ? ST_STEP : ST_CLEAR;
            end
          end
        end
        ST_CLEAR: begin
          if (resync) begin
            state_d = ST_LOAD;
          end else if (tick_en && clear_done) begin
            state_d = ST_STEP;
          end
        end
        // A STEP whose pulse was swallowed by a freeze re-issues it on resume.
        ST_STEP: begin
          if (advance_q) state_d = ST_LOAD;
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_comb begin
    phase_d     = phase_q;
    elapsed_d   = elapsed_q;
    remaining_d = remaining_q;
    presc_clear = 1'b0;
    all_red_d   = (state_d == ST_CLEAR);
    advance_d   = enable && (state_d == ST_STEP) &&
                  !((state_q == ST_STEP) && advance_q);
    if (enable) begin
      case (state_q)
        ST_LOAD: begin
          phase_d     = phase_i;
          elapsed_d   = '0;
          remaining_d = phase_is_green(phase_i) ? G_MIN : Y_T;
          presc_clear = 1'b1;
        end
        ST_COUNT, ST_CLEAR: begin
          if (!resync && tick_en) begin
            elapsed_d   = elapsed_inc;
            remaining_d = (remaining_q == '0) ? '0 : remaining_q - 1'b1;
          end
          if ((state_d == ST_CLEAR) && (state_q != ST_CLEAR)) begin
            elapsed_d   = '0;
            presc_clear = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Demand latches keep capturing while frozen; the own-green load clears them.
  always_comb begin
    dem_ns_d = dem_ns_q | car_ns | (ped_req & phase_is_ew(phase_i));
    dem_ew_d = dem_ew_q | car_ew | (ped_req & ~phase_is_ew(phase_i));
    if (enable && (state_q == ST_LOAD)) begin
      if (phase_i == PH_NS_GREEN) dem_ns_d = 1'b0;
      if (phase_i == PH_EW_GREEN) dem_ew_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q     <= PH_NS_GREEN;
      elapsed_q   <= '0;
      remaining_q <= '0;
      dem_ns_q    <= 1'b0;
      dem_ew_q    <= 1'b0;
      advance_q   <= 1'b0;
      all_red_q   <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      elapsed_q   <= elapsed_d;
      remaining_q <= remaining_d;
      dem_ns_q    <= dem_ns_d;
      dem_ew_q    <= dem_ew_d;
      advance_q   <= advance_d;
      all_red_q   <= all_red_d;
    end
  end

  assign advance_o   = advance_q;
  assign all_red_o   = all_red_q;
  assign tick_o      = tick;
  assign remaining_o = remaining_q;

endmodule
